opn_adpcm_mem_arb: RTL and testbench
====================================

Name: opn_adpcm_mem_arb

Overview:
- Parametrised shared-memory arbiter for the ADPCM sample memory of one or more OPN-family sound cores.
- Lets NCH byte-wide requestor channels share one external memory port. Typical channels are ADPCM-B RAM, rhythm/ADPCM-A ROM, and a second chip's ADPCM.
- Sits between the sound-core ADPCM pins and the board memory.
- Latches pulse-style requests, arbitrates round-robin, drives a fixed-latency memory port, and returns held read data with a per-channel acknowledge.

Parameters:
- NCH, 3: number of requestor channels (1..8).
- AW, 18: byte address width, shared by channels and memory.
- RD_LAT, 2: memory read latency in cycles from mem_rd high to mem_rdata valid (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ch_rd  in  NCH  per-channel read request pulse.
- ch_wr  in  NCH  per-channel write request pulse.
- ch_addr  in  NCH*AW  channel i address in bits [i*AW +: AW].
- ch_wdata  in  NCH*8  channel i write byte in bits [i*8 +: 8].
- ch_rdata  out  NCH*8  channel i last read byte, held until next read completion.
- ch_ack  out  NCH  one-cycle completion pulse per channel.
- ch_ovf  out  NCH  sticky overrun flag per channel.
- ch_ovf_clr  in  NCH  clears ch_ovf[i].
- mem_addr  out  AW  memory address.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte, valid RD_LAT cycles after mem_rd.

Behaviour:
- Reset: every output is 0, all pending slots are cleared, the FSM is in IDLE and rr_ptr=0.
- Reset mid-access aborts the access. No ack is issued and ch_rdata is cleared.
- Capture:
  - A request is ch_rd[i] | ch_wr[i] sampled high in cycle T. It latches addr, wdata and type into slot i and sets pend[i] at T+1.
  - If ch_rd and ch_wr are both high, the request is a write.
  - If pend[i] is already set and slot i is not being granted in cycle T, the new request overwrites the slot (latest wins) and ch_ovf[i] is set.
  - If slot i is being granted in cycle T, the new request becomes a fresh pending entry and ch_ovf is not set.
  - ch_ovf_clr[i] clears ch_ovf[i]. If a clear and a set occur in the same cycle, set wins.
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If any pend bit is set, grant the first set index searching upward from rr_ptr with wrap-around.
  - Copy the slot to the grant register, clear its pend bit and go to ISSUE.
  - Set rr_ptr = grant+1 mod NCH.
- ISSUE (1 cycle):
  - mem_addr = slot addr; mem_rd or mem_wr = 1; mem_wdata = slot wdata for writes.
  - A write goes to IDLE, and ch_ack[grant] is high in the next cycle.
  - A read goes to WAIT, or to DONE directly if RD_LAT=1.
- WAIT: stays RD_LAT-1 cycles (counter), then goes to DONE.
- DONE: in the cycle when mem_rdata is valid, load mem_rdata into ch_rdata[grant]. ch_ack[grant] is high in the next cycle, coinciding with the new rdata. Return to IDLE.
- Timing for a request at cycle T with an idle arbiter:
  - ISSUE at T+2.
  - Read ack at T+3+RD_LAT; write ack at T+3.
  - Back-to-back reads from different channels issue every RD_LAT+2 cycles.
- Outside ISSUE, mem_rd=mem_wr=0. mem_addr holds its last value.
- Only the granted channel's rdata changes. Other channels' rdata is stable.
- NCH=1: rr_ptr stays 0.

Test Plan:
- Single read: RD_LAT=2, ch_rd[0] at T=10, addr 0x01234, memory model returns 0xA5 -> mem_rd high at T=12 with mem_addr=0x01234; ch_ack[0] at T=15; ch_rdata[0]=0xA5 from T=15.
- Write: ch_wr[1] at T=10, addr 0x3FFFF, data 0x5A -> mem_wr high at T=12, mem_addr=0x3FFFF, mem_wdata=0x5A; ch_ack[1] at T=13; no mem_rd.
- Round-robin: reads on ch 0,1,2 all pulsed at T=10 with rr_ptr=0 -> grants in order 0,1,2, mem_rd at T=12, 16, 20. Re-pulse all three; rr_ptr must be 0 again -> same order.
- Overrun: ch_rd[2] at T=10 while ch0's read is in WAIT, then ch_wr[2] at T=11 with addr 0x00100 -> ch_ovf[2]=1; a single write to 0x00100 is issued; ch_ovf_clr[2] clears the flag.
- rd+wr together: ch_rd[0]=ch_wr[0]=1 -> only mem_wr strobes; ch_rdata[0] is unchanged.
- Reset mid-WAIT: assert rst during WAIT of a ch1 read -> no ch_ack; all outputs 0; the next request after release issues normally at T+2.

Source files
------------

// File: rtl/opn_adpcm_mem_arb.sv
// opn_adpcm_mem_arb: round-robin arbiter sharing one fixed-latency byte memory among NCH ADPCM channels
module opn_adpcm_mem_arb #(
    parameter int NCH    = 3,
    parameter int AW     = 18,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_rd,
    input  logic [NCH-1:0]    ch_wr,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*8-1:0]  ch_wdata,
    output logic [NCH*8-1:0]  ch_rdata,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_ovf,
    input  logic [NCH-1:0]    ch_ovf_clr,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [NCH-1:0] pend, slot_wr, req, take;
    logic [AW-1:0] slot_addr [NCH];
    logic [7:0] slot_wdata [NCH];
    logic [IW-1:0] rr_ptr, gnt, sel;
    logic found, gnt_wr;
    logic [CW-1:0] wcnt;
    assign req = ch_rd | ch_wr;
    // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment
    always_comb begin
        sel = '0;
        found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--)
            if (pend[(int'(rr_ptr) + k) % NCH]) begin
                sel = IW'((int'(rr_ptr) + k) % NCH);
                found = 1'b1;
            end
        take = (state == IDLE && found) ? NCH'(1) << sel : '0;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (found) state_nx = ISSUE;
            ISSUE: state_nx = gnt_wr ? IDLE : (RD_LAT == 1 ? DONE : WAIT);
            WAIT:  if (wcnt == CW'(RD_LAT - 2)) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end
    // A slot being granted this cycle hands its contents to the grant path, so a new request there is not an overrun
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend <= '0;
            slot_wr <= '0;
            ch_ovf <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_addr[i] <= '0;
                slot_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++)
                if (req[i]) begin
                    slot_addr[i] <= ch_addr[i*AW +: AW];
                    slot_wdata[i] <= ch_wdata[i*8 +: 8];
                    slot_wr[i] <= ch_wr[i];
                end
            pend <= req | (pend & ~take);
            ch_ovf <= (req & pend & ~take) | (ch_ovf & ~ch_ovf_clr);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt <= '0;
            gnt_wr <= 1'b0;
            wcnt <= '0;
            mem_addr <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            mem_wdata <= '0;
            ch_ack <= '0;
            ch_rdata <= '0;
        end else begin
            state <= state_nx;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            ch_ack <= '0;
            wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
            if (state == IDLE && found) begin
                gnt <= sel;
                gnt_wr <= slot_wr[sel];
                rr_ptr <= sel == IW'(NCH - 1) ? '0 : sel + 1'b1;
                mem_addr <= slot_addr[sel];
                mem_rd <= ~slot_wr[sel];
                mem_wr <= slot_wr[sel];
                if (slot_wr[sel]) mem_wdata <= slot_wdata[sel];
            end
            if (state == ISSUE && gnt_wr) ch_ack[gnt] <= 1'b1;
            if (state == DONE) begin
                ch_rdata[gnt*8 +: 8] <= mem_rdata;
                ch_ack[gnt] <= 1'b1;
            end
        end
endmodule

// File: tb/tb_opn_adpcm_mem_arb.sv
// tb_opn_adpcm_mem_arb: scoreboard bench with a fixed-latency memory model for opn_adpcm_mem_arb
module tb_opn_adpcm_mem_arb;
    localparam int NCH = 3, AW = 18, RD_LAT = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic [NCH-1:0] ch_rd, ch_wr, ch_ack, ch_ovf, ch_ovf_clr;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*8-1:0] ch_wdata, ch_rdata;
    logic [AW-1:0] mem_addr;
    logic mem_rd, mem_wr;
    logic [7:0] mem_wdata, mem_rdata;

    opn_adpcm_mem_arb #(.NCH(NCH), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack), .ch_ovf(ch_ovf),
        .ch_ovf_clr(ch_ovf_clr), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, passed = 0;

    function automatic logic [7:0] seed(input logic [AW-1:0] a);
        return a == AW'(18'h01234) ? 8'hA5 : a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Memory model: data appears RD_LAT cycles after mem_rd, garbage otherwise
    logic [7:0] mem [1024];
    logic mem_ok [1024];
    logic [7:0] pipe_d [RD_LAT];
    logic pipe_v [RD_LAT];
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            mem_ok[mem_addr[9:0]] <= 1'b1;
        end
        pipe_v[0] <= mem_rd;
        pipe_d[0] <= mem_ok[mem_addr[9:0]] ? mem[mem_addr[9:0]] : seed(mem_addr);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 8'hEE;

    logic [7:0] ref_mem [1024];
    bit ref_ok [1024];
    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_ok[a[9:0]] ? ref_mem[a[9:0]] : seed(a);
    endfunction

    typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [7:0] wd; } mop_t;
    typedef struct { int cyc; int ch; bit rd; logic [7:0] data; } ack_t;
    mop_t mq[$];
    ack_t aq[$];
    mop_t me;
    ack_t ae;
    logic [NCH-1:0] am;
    logic [NCH*8-1:0] shadow = '0;

    always @(negedge clk) if (!rst) begin
        if (mem_rd || mem_wr) begin
            checks++;
            if (mq.size() == 0)
                $display("FAIL mem_op: got rd=%0b wr=%0b addr=%h at cycle %0d, required no access", mem_rd, mem_wr, mem_addr, cyc);
            else begin
                me = mq.pop_front();
                if ({cyc, mem_wr, mem_rd, mem_addr, mem_wr ? mem_wdata : 8'h00} !==
                    {me.cyc, me.wr, !me.wr, me.addr, me.wr ? me.wd : 8'h00})
                    $display("FAIL mem_op: got cyc=%0d wr=%0b rd=%0b addr=%h wd=%h, required cyc=%0d wr=%0b addr=%h wd=%h",
                             cyc, mem_wr, mem_rd, mem_addr, mem_wdata, me.cyc, me.wr, me.addr, me.wd);
                else passed++;
            end
        end
        if (ch_ack != '0) begin
            checks++;
            if (aq.size() == 0)
                $display("FAIL ch_ack: got %b at cycle %0d, required none", ch_ack, cyc);
            else begin
                ae = aq.pop_front();
                am = '0;
                am[ae.ch] = 1'b1;
                if ({cyc, ch_ack, ae.rd ? ch_rdata[ae.ch*8 +: 8] : 8'h00} !== {ae.cyc, am, ae.rd ? ae.data : 8'h00})
                    $display("FAIL ch_ack: got cyc=%0d ack=%b rdata=%h, required cyc=%0d ack=%b rdata=%h",
                             cyc, ch_ack, ch_rdata[ae.ch*8 +: 8], ae.cyc, am, ae.data);
                else passed++;
                if (ae.rd) shadow[ae.ch*8 +: 8] = ae.data;
                checks++;
                if (ch_rdata !== shadow) $display("FAIL ch_rdata_all: got %h, required %h", ch_rdata, shadow);
                else passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [7:0] d);
        ch_rd[ch] = rd;
        ch_wr[ch] = wr;
        ch_addr[ch*AW +: AW] = a;
        ch_wdata[ch*8 +: 8] = d;
    endtask

    task automatic idle_req();
        ch_rd = '0;
        ch_wr = '0;
    endtask

    task automatic exp_read(input int ch, input logic [AW-1:0] a, input int ti);
        mq.push_back('{ti, 1'b0, a, 8'h00});
        aq.push_back('{ti + 1 + RD_LAT, ch, 1'b1, ref_rd(a)});
    endtask

    task automatic exp_write(input int ch, input logic [AW-1:0] a, input logic [7:0] d, input int ti);
        mq.push_back('{ti, 1'b1, a, d});
        aq.push_back('{ti + 1, ch, 1'b0, 8'h00});
        ref_mem[a[9:0]] = d;
        ref_ok[a[9:0]] = 1'b1;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((mq.size() != 0 || aq.size() != 0) && n < 100) begin
            step();
            n++;
        end
        ok = mq.size() == 0 && aq.size() == 0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ch_rdata, ch_ack, ch_ovf, mem_addr, mem_rd, mem_wr, mem_wdata} !== '0)
            $display("FAIL reset_outputs: got %h, required 0", {ch_rdata, ch_ack, ch_ovf, mem_addr, mem_rd, mem_wr, mem_wdata});
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        int t = cyc;
        bit ok;
        drive(0, 1, 0, AW'(18'h01234), 8'h00);
        exp_read(0, AW'(18'h01234), t + 2);
        step();
        idle_req();
        drain(ok);
        checks++;
        if (!ok || ch_rdata[7:0] !== 8'hA5) $display("FAIL single_read: drained=%0b rdata=%h, required 1 a5", ok, ch_rdata[7:0]);
        else passed++;
    endtask

    task automatic test_write();
        int t = cyc;
        bit ok;
        drive(1, 0, 1, AW'(18'h3FFFF), 8'h5A);
        exp_write(1, AW'(18'h3FFFF), 8'h5A, t + 2);
        step();
        idle_req();
        drain(ok);
        checks++;
        if (!ok) $display("FAIL write: queues drained=%0b, required 1", ok);
        else passed++;
    endtask

    task automatic test_round_robin();
        int t;
        bit ok, all = 1'b1;
        t = cyc;
        drive(2, 1, 0, AW'(18'h0003F), 8'h00);
        exp_read(2, AW'(18'h0003F), t + 2);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        for (int r = 0; r < 2; r++) begin
            t = cyc;
            for (int c = 0; c < NCH; c++) begin
                drive(c, 1, 0, AW'(16 * (c + 1) + r), 8'h00);
                exp_read(c, AW'(16 * (c + 1) + r), t + 2 + c * (RD_LAT + 2));
            end
            step();
            idle_req();
            drain(ok);
            all &= ok;
        end
        t = cyc;
        drive(0, 1, 0, AW'(18'h80), 8'h00);
        exp_read(0, AW'(18'h80), t + 2);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        t = cyc;
        drive(0, 1, 0, AW'(18'h81), 8'h00);
        drive(2, 1, 0, AW'(18'h82), 8'h00);
        exp_read(2, AW'(18'h82), t + 2);
        exp_read(0, AW'(18'h81), t + 4 + RD_LAT);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        checks++;
        if (!all) $display("FAIL round_robin: queues drained=%0b, required 1", all);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t = cyc;
        bit ok, all = 1'b1;
        drive(0, 0, 1, AW'(18'h41), 8'h3E);
        drive(2, 0, 1, AW'(18'h40), 8'h9C);
        exp_write(2, AW'(18'h40), 8'h9C, t + 2);
        exp_write(0, AW'(18'h41), 8'h3E, t + 4);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        t = cyc;
        drive(1, 1, 0, AW'(18'h40), 8'h00);
        exp_read(1, AW'(18'h40), t + 2);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        checks++;
        if (!all || ch_rdata[15:8] !== 8'h9C) $display("FAIL back_to_back: drained=%0b rdata1=%h, required 1 9c", all, ch_rdata[15:8]);
        else passed++;
    endtask

    task automatic test_overrun();
        int t = cyc;
        bit ok;
        drive(0, 1, 0, AW'(18'h50), 8'h00);
        exp_read(0, AW'(18'h50), t + 2);
        step();
        idle_req();
        step();
        step();
        drive(2, 1, 0, AW'(18'h200), 8'h00);
        step();
        drive(2, 0, 1, AW'(18'h100), 8'h77);
        exp_write(2, AW'(18'h100), 8'h77, t + 6);
        step();
        idle_req();
        checks++;
        if (ch_ovf !== 3'b100) $display("FAIL overrun_set: got %b, required 100", ch_ovf);
        else passed++;
        drain(ok);
        checks++;
        if (!ok) $display("FAIL overrun_drain: drained=%0b, required 1", ok);
        else passed++;
        ch_ovf_clr[2] = 1'b1;
        step();
        ch_ovf_clr = '0;
        checks++;
        if (ch_ovf !== 3'b000) $display("FAIL overrun_clear: got %b, required 000", ch_ovf);
        else passed++;
        // set and clear in the same cycle: set must win
        t = cyc;
        drive(0, 1, 0, AW'(18'h51), 8'h00);
        exp_read(0, AW'(18'h51), t + 2);
        step();
        idle_req();
        step();
        drive(2, 1, 0, AW'(18'h201), 8'h00);
        step();
        drive(2, 1, 0, AW'(18'h202), 8'h00);
        ch_ovf_clr[2] = 1'b1;
        exp_read(2, AW'(18'h202), t + 6);
        step();
        idle_req();
        ch_ovf_clr = '0;
        checks++;
        if (ch_ovf !== 3'b100) $display("FAIL ovf_set_wins: got %b, required 100", ch_ovf);
        else passed++;
        drain(ok);
        ch_ovf_clr[2] = 1'b1;
        step();
        ch_ovf_clr = '0;
        checks++;
        if (!ok || ch_ovf !== 3'b000) $display("FAIL ovf_set_wins_drain: drained=%0b ovf=%b, required 1 000", ok, ch_ovf);
        else passed++;
    endtask

    task automatic test_grant_same_cycle();
        int t = cyc;
        bit ok;
        drive(0, 1, 0, AW'(18'h52), 8'h00);
        exp_read(0, AW'(18'h52), t + 2);
        step();
        drive(0, 1, 0, AW'(18'h53), 8'h00);
        exp_read(0, AW'(18'h53), t + 6);
        step();
        idle_req();
        checks++;
        if (ch_ovf !== 3'b000) $display("FAIL grant_same_cycle_ovf: got %b, required 000", ch_ovf);
        else passed++;
        drain(ok);
        checks++;
        if (!ok) $display("FAIL grant_same_cycle: drained=%0b, required 1", ok);
        else passed++;
    endtask

    task automatic test_rd_wr_both();
        int t = cyc;
        bit ok, all = 1'b1;
        drive(0, 1, 1, AW'(18'h60), 8'hC3);
        exp_write(0, AW'(18'h60), 8'hC3, t + 2);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        checks++;
        if (ch_rdata[7:0] !== shadow[7:0]) $display("FAIL rd_wr_rdata: got %h, required %h", ch_rdata[7:0], shadow[7:0]);
        else passed++;
        t = cyc;
        drive(0, 1, 0, AW'(18'h60), 8'h00);
        exp_read(0, AW'(18'h60), t + 2);
        step();
        idle_req();
        drain(ok);
        all &= ok;
        checks++;
        if (!all || ch_rdata[7:0] !== 8'hC3) $display("FAIL rd_wr_both: drained=%0b rdata0=%h, required 1 c3", all, ch_rdata[7:0]);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int t = cyc;
        bit ok;
        drive(1, 1, 0, AW'(18'h70), 8'h00);
        mq.push_back('{t + 2, 1'b0, AW'(18'h70), 8'h00});
        step();
        idle_req();
        step();
        step();
        rst = 1'b1;
        #1;
        shadow = '0;
        checks++;
        if ({ch_rdata, ch_ack, ch_ovf, mem_addr, mem_rd, mem_wr, mem_wdata} !== '0)
            $display("FAIL reset_mid_wait: got %h, required 0", {ch_rdata, ch_ack, ch_ovf, mem_addr, mem_rd, mem_wr, mem_wdata});
        else passed++;
        step();
        step();
        rst = 1'b0;
        step();
        t = cyc;
        drive(1, 1, 0, AW'(18'h71), 8'h00);
        exp_read(1, AW'(18'h71), t + 2);
        step();
        idle_req();
        drain(ok);
        repeat (4) step();
        checks++;
        if (!ok) $display("FAIL after_reset: drained=%0b, required 1", ok);
        else passed++;
    endtask

    initial begin
        ch_rd = '0;
        ch_wr = '0;
        ch_addr = '0;
        ch_wdata = '0;
        ch_ovf_clr = '0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_back_to_back();
        test_overrun();
        test_grant_same_cycle();
        test_rd_wr_both();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
